fetch_queue: RTL and testbench

Instruction fetch front end for the five-stage MIPS pipeline. It owns the PC, issues word fetches to an instruction memory over a req/ack handshake that tolerates variable latency, and buffers returned instructions with their PC+4 in a small FIFO. The FIFO head drives the IF/DEC pipeline register. Stage-3 branch, jump and jr redirects flush the queue and restart fetch at the target.

---
 rtl/fetch_queue_if.sv | 24 ++
 rtl/fetch_queue.sv | 154 +++++++++++++++
 tb/tb_fetch_queue.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: instruction-memory handshake, stage-3 redirect and decode-side head.
// master = fetch_queue side, slave = memory/pipeline side.
interface fetch_queue_if;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemAck;
    logic [31:0] ImemData;
    logic        Redirect;
    logic [31:0] RedirectAddr;
    logic        Stall;
    logic [31:0] InstructionOut;
    logic [31:0] PC4Out;
    logic        Valid;

    modport master (
        output ImemReq, ImemAddr, InstructionOut, PC4Out, Valid,
        input  ImemAck, ImemData, Redirect, RedirectAddr, Stall
    );

    modport slave (
        input  ImemReq, ImemAddr, InstructionOut, PC4Out, Valid,
        output ImemAck, ImemData, Redirect, RedirectAddr, Stall
    );
endinterface

// File: rtl/fetch_queue.sv
// MIPS fetch front end: PC, single-outstanding imem fetch FSM and instruction FIFO.
// Define FETCH_PERF_EN to add the FetchCount/FlushCount performance counters.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic           Clk,
    input logic           Rst,
    fetch_queue_if.master bus_io
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]   FetchCount,
    output logic [31:0]   FlushCount
`endif
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDrop} state_e;

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       addr_q, addr_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [31:0]       instr_mem [DEPTH];
    logic [31:0]       pc4_mem   [DEPTH];

    logic req, valid, push, pop, pending, issue_ok;

    always_comb begin
        req     = (state_q != StIdle);
        valid   = (count_q != '0);
        // Only data fetched in BUSY belongs to the current stream; DROP data is stale.
        push    = (state_q == StBusy) && bus_io.ImemAck && !bus_io.Redirect;
        pop     = valid && !bus_io.Stall && !bus_io.Redirect;
        pending = req && !bus_io.ImemAck;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus_io.Redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Occupancy after this edge; any in-flight request has completed when this is used.
    assign issue_ok = (count_d < CntW'(DEPTH));

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        if (bus_io.Redirect) begin
            pc_d = {bus_io.RedirectAddr[31:2], 2'b00};
            if (pending) begin
                state_d = StDrop;
                // Entering DROP from BUSY: freeze the in-flight address.
                if (state_q == StBusy) addr_d = pc_q;
            end else begin
                state_d = StBusy;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    if (issue_ok) state_d = StBusy;
                end
                StBusy: begin
                    if (bus_io.ImemAck) begin
                        pc_d    = pc_q + 32'd4;
                        state_d = issue_ok ? StBusy : StIdle;
                    end
                end
                StDrop: begin
                    if (bus_io.ImemAck) state_d = issue_ok ? StBusy : StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q  <= StIdle;
            pc_q     <= {RESET_PC[31:2], 2'b00};
            addr_q   <= {RESET_PC[31:2], 2'b00};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= bus_io.ImemData;
            pc4_mem[wr_ptr_q]   <= pc_q + 32'd4;
        end
    end

    always_comb begin
        bus_io.ImemReq        = req;
        bus_io.ImemAddr       = (state_q == StDrop) ? addr_q : pc_q;
        bus_io.Valid          = valid;
        bus_io.InstructionOut = valid ? instr_mem[rd_ptr_q] : 32'h0;
        bus_io.PC4Out         = valid ? pc4_mem[rd_ptr_q] : 32'h0;
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (push)            fetch_cnt_d = fetch_cnt_q + 32'd1;
        if (bus_io.Redirect) flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign FetchCount = fetch_cnt_q;
    assign FlushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: variable-latency memory model plus
// scoreboard of expected {instruction, pc+4} built from bench-predicted fetch addresses.
module tb_fetch_queue;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc4;
    } ent_t;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    int          lat;
    int          wait_cnt;
    int          kept;
    logic        prev_req;
    logic        prev_ack;
    logic        drop;
    logic [31:0] nf;
    ent_t        sb[$];
    ent_t        sb2[$];

    fetch_queue_if bus ();
    fetch_queue_if bus2 ();

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt, flush_cnt, fetch_cnt2, flush_cnt2;
`endif

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .bus_io (bus)
`ifdef FETCH_PERF_EN
        ,
        .FetchCount (fetch_cnt),
        .FlushCount (flush_cnt)
`endif
    );

    fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .Clk    (Clk),
        .Rst    (Rst),
        .bus_io (bus2)
`ifdef FETCH_PERF_EN
        ,
        .FetchCount (fetch_cnt2),
        .FlushCount (flush_cnt2)
`endif
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    // Wrap instance: zero-wait memory, stalled decode unless a test releases it.
    assign bus2.ImemAck      = 1'b1;
    assign bus2.ImemData     = mem_word(bus2.ImemAddr);
    assign bus2.Redirect     = 1'b0;
    assign bus2.RedirectAddr = 32'h0;

    // One clock: memory responds at the falling edge; expected entries pushed on kept acks.
    task automatic tick(input logic stall, input logic redir, input logic [31:0] raddr);
        ent_t e;
        logic ack;
        @(posedge Clk);
        @(negedge Clk);
        if (prev_req && prev_ack) wait_cnt = 0;
        else if (prev_req)        wait_cnt++;
        bus.Stall        = stall;
        bus.Redirect     = redir;
        bus.RedirectAddr = raddr;
        ack              = bus.ImemReq && (wait_cnt >= lat);
        bus.ImemAck      = ack;
        bus.ImemData     = ack ? mem_word(bus.ImemAddr) : 32'hDEAD_BEEF;
        if (redir) begin
            sb.delete();
            drop = bus.ImemReq && !ack;
            nf   = {raddr[31:2], 2'b00};
        end else if (ack) begin
            if (!drop) begin
                e.ins = mem_word(nf);
                e.pc4 = nf + 32'd4;
                sb.push_back(e);
                nf = nf + 32'd4;
                kept++;
            end
            drop = 1'b0;
        end
        prev_req = bus.ImemReq;
        prev_ack = ack;
    endtask

    task automatic do_reset(input int l);
        @(negedge Clk);
        Rst = 1'b0;
        bus.Stall = 1'b0; bus.Redirect = 1'b0; bus.RedirectAddr = 32'h0;
        bus.ImemAck = 1'b0; bus.ImemData = 32'h0;
        lat = l; wait_cnt = 0; prev_req = 1'b0; prev_ack = 1'b0;
        drop = 1'b0; nf = 32'h0; kept = 0;
        sb.delete();
        @(negedge Clk);
        Rst = 1'b1;
    endtask

    task automatic test_reset();
        bus.Stall = 1'b0; bus.Redirect = 1'b0; bus.RedirectAddr = 32'h0;
        bus.ImemAck = 1'b0; bus.ImemData = 32'h0;
        Rst = 1'b0;
        repeat (2) @(negedge Clk);
        total++; if (bus.ImemReq !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", bus.ImemReq); end
        total++; if (bus.ImemAddr !== 32'h0) begin bad++; $display("FAIL rst_addr: got %h want 0", bus.ImemAddr); end
        total++; if (bus.Valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", bus.Valid); end
        total++; if (bus.InstructionOut !== 32'h0) begin bad++; $display("FAIL rst_ins: got %h want 0", bus.InstructionOut); end
        total++; if (bus.PC4Out !== 32'h0) begin bad++; $display("FAIL rst_pc4: got %h want 0", bus.PC4Out); end
        total++; if (bus2.ImemAddr !== 32'hFFFF_FFF8) begin bad++; $display("FAIL rst_wrap_addr: got %h want fffffff8", bus2.ImemAddr); end
`ifdef FETCH_PERF_EN
        total++; if (fetch_cnt !== 32'h0 || flush_cnt !== 32'h0) begin bad++; $display("FAIL rst_perf: got %h/%h want 0/0", fetch_cnt, flush_cnt); end
`endif
        lat = 0; wait_cnt = 0; prev_req = 1'b0; prev_ack = 1'b0;
        drop = 1'b0; nf = 32'h0; kept = 0; sb.delete();
        Rst = 1'b1;
        tick(1'b0, 1'b0, 32'h0);
        total++; if (bus.ImemReq !== 1'b1) begin bad++; $display("FAIL first_req: got %b want 1", bus.ImemReq); end
        total++; if (bus.Valid !== 1'b0) begin bad++; $display("FAIL first_valid: got %b want 0", bus.Valid); end
    endtask

    task automatic test_stream();
        ent_t e;
        logic [31:0] ea;
        do_reset(0);
        for (int i = 0; i < 14; i++) begin
            tick(1'b0, 1'b0, 32'h0);
            ea = i * 4;
            total++; if (bus.ImemAddr !== ea) begin bad++; $display("FAIL stream_addr: got %h want %h", bus.ImemAddr, ea); end
            if (i > 0) begin
                total++; if (bus.Valid !== 1'b1) begin bad++; $display("FAIL stream_gap: valid got %b want 1 at %0d", bus.Valid, i); end
            end
            if (bus.Valid && !bus.Stall && !bus.Redirect) begin
                total++;
                if (sb.size() == 0) begin bad++; $display("FAIL stream_pop: unexpected ins %h pc4 %h", bus.InstructionOut, bus.PC4Out); end
                else begin
                    e = sb.pop_front();
                    if (bus.InstructionOut !== e.ins || bus.PC4Out !== e.pc4) begin
                        bad++; $display("FAIL stream_pop: got %h/%h want %h/%h", bus.InstructionOut, bus.PC4Out, e.ins, e.pc4);
                    end
                end
            end
        end
    endtask

    task automatic test_stall();
        ent_t e;
        int   pops;
        logic seen;
        do_reset(0);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 32'h0);
        total++; if (bus.ImemReq !== 1'b0) begin bad++; $display("FAIL stall_req: got %b want 0", bus.ImemReq); end
        total++; if (sb.size() != 4) begin bad++; $display("FAIL stall_fetches: got %0d want 4", sb.size()); end
        total++; if (bus.Valid !== 1'b1) begin bad++; $display("FAIL stall_valid: got %b want 1", bus.Valid); end
        pops = 0; seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b0, 32'h0);
            if (!seen && bus.ImemReq) begin
                seen = 1'b1;
                total++; if (bus.ImemAddr !== 32'h10) begin bad++; $display("FAIL stall_resume: got %h want 00000010", bus.ImemAddr); end
            end
            if (bus.Valid && !bus.Stall && !bus.Redirect) begin
                total++; pops++;
                if (sb.size() == 0) begin bad++; $display("FAIL stall_pop: unexpected ins %h", bus.InstructionOut); end
                else begin
                    e = sb.pop_front();
                    if (bus.InstructionOut !== e.ins || bus.PC4Out !== e.pc4) begin
                        bad++; $display("FAIL stall_pop: got %h/%h want %h/%h", bus.InstructionOut, bus.PC4Out, e.ins, e.pc4);
                    end
                end
            end
        end
        total++; if (!seen) begin bad++; $display("FAIL stall_resume: no request got 0 want 1"); end
        total++; if (pops != 8) begin bad++; $display("FAIL stall_pops: got %0d want 8", pops); end
    endtask

    task automatic test_latency();
        ent_t        e;
        int          pops;
        logic        lreq, lack;
        logic [31:0] laddr;
        do_reset(3);
        pops = 0; lreq = 1'b0; lack = 1'b0; laddr = 32'h0;
        for (int i = 0; i < 24; i++) begin
            tick(1'b0, 1'b0, 32'h0);
            if (lreq && !lack && bus.ImemReq) begin
                total++; if (bus.ImemAddr !== laddr) begin bad++; $display("FAIL lat_addr_stable: got %h want %h", bus.ImemAddr, laddr); end
            end
            if (bus.Valid && !bus.Stall && !bus.Redirect) begin
                total++; pops++;
                if (sb.size() == 0) begin bad++; $display("FAIL lat_pop: unexpected ins %h", bus.InstructionOut); end
                else begin
                    e = sb.pop_front();
                    if (bus.InstructionOut !== e.ins || bus.PC4Out !== e.pc4) begin
                        bad++; $display("FAIL lat_pop: got %h/%h want %h/%h", bus.InstructionOut, bus.PC4Out, e.ins, e.pc4);
                    end
                end
            end
            lreq = bus.ImemReq; lack = bus.ImemAck; laddr = bus.ImemAddr;
        end
        total++; if (pops != 5) begin bad++; $display("FAIL lat_rate: got %0d want 5", pops); end
    endtask

    task automatic test_redirect_pending();
        ent_t        e;
        int          pops;
        logic        found, seen;
        logic [31:0] first_pc4;
        do_reset(3);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(1'b0, 1'b0, 32'h0);
            if (bus.Valid && !bus.Stall && !bus.Redirect) begin
                total++;
                if (sb.size() == 0) begin bad++; $display("FAIL redir_pre_pop: unexpected ins %h", bus.InstructionOut); end
                else begin
                    e = sb.pop_front();
                    if (bus.InstructionOut !== e.ins || bus.PC4Out !== e.pc4) begin
                        bad++; $display("FAIL redir_pre_pop: got %h/%h want %h/%h", bus.InstructionOut, bus.PC4Out, e.ins, e.pc4);
                    end
                end
            end
            if (bus.ImemReq && bus.ImemAddr == 32'h8) found = 1'b1;
        end
        total++; if (!found) begin bad++; $display("FAIL redir_wait8: got timeout want fetch of 00000008"); end
        tick(1'b0, 1'b1, 32'h100);
        tick(1'b0, 1'b0, 32'h0);
        total++; if (bus.Valid !== 1'b0) begin bad++; $display("FAIL redir_flush: valid got %b want 0", bus.Valid); end
        total++; if (bus.InstructionOut !== 32'h0) begin bad++; $display("FAIL redir_nop: got %h want 0", bus.InstructionOut); end
        total++; if (bus.ImemReq !== 1'b1 || bus.ImemAddr !== 32'h8) begin
            bad++; $display("FAIL redir_drop_hold: got %b/%h want 1/00000008", bus.ImemReq, bus.ImemAddr);
        end
        pops = 0; seen = 1'b0; first_pc4 = 32'h0;
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 1'b0, 32'h0);
            if (!seen && bus.ImemReq && bus.ImemAddr != 32'h8) begin
                seen = 1'b1;
                total++; if (bus.ImemAddr !== 32'h100) begin bad++; $display("FAIL redir_target: got %h want 00000100", bus.ImemAddr); end
            end
            if (bus.Valid && !bus.Stall && !bus.Redirect) begin
                total++;
                if (pops == 0) first_pc4 = bus.PC4Out;
                pops++;
                if (sb.size() == 0) begin bad++; $display("FAIL redir_pop: unexpected ins %h", bus.InstructionOut); end
                else begin
                    e = sb.pop_front();
                    if (bus.InstructionOut !== e.ins || bus.PC4Out !== e.pc4) begin
                        bad++; $display("FAIL redir_pop: got %h/%h want %h/%h", bus.InstructionOut, bus.PC4Out, e.ins, e.pc4);
                    end
                end
            end
        end
        total++; if (pops < 1 || first_pc4 !== 32'h104) begin
            bad++; $display("FAIL redir_first: got pops %0d pc4 %h want >=1 / 00000104", pops, first_pc4);
        end
    endtask

    task automatic test_redirect_same_edge();
        ent_t e;
        do_reset(0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 32'h0);
            if (bus.Valid && !bus.Stall && !bus.Redirect) begin
                total++;
                if (sb.size() == 0) begin bad++; $display("FAIL same_pre_pop: unexpected ins %h", bus.InstructionOut); end
                else begin
                    e = sb.pop_front();
                    if (bus.InstructionOut !== e.ins || bus.PC4Out !== e.pc4) begin
                        bad++; $display("FAIL same_pre_pop: got %h/%h want %h/%h", bus.InstructionOut, bus.PC4Out, e.ins, e.pc4);
                    end
                end
            end
        end
        // Valid, ack and redirect all coincide here; low address bits must be ignored.
        tick(1'b0, 1'b1, 32'h202);
        tick(1'b0, 1'b0, 32'h0);
        total++; if (bus.Valid !== 1'b0) begin bad++; $display("FAIL same_flush: valid got %b want 0", bus.Valid); end
        total++; if (bus.ImemReq !== 1'b1 || bus.ImemAddr !== 32'h200) begin
            bad++; $display("FAIL same_target: got %b/%h want 1/00000200", bus.ImemReq, bus.ImemAddr);
        end
`ifdef FETCH_PERF_EN
        total++; if (flush_cnt !== 32'd1) begin bad++; $display("FAIL same_flushcount: got %0d want 1", flush_cnt); end
        total++; if (fetch_cnt !== 32'd3) begin bad++; $display("FAIL same_fetchcount: got %0d want 3", fetch_cnt); end
`endif
        tick(1'b0, 1'b0, 32'h0);
        total++; if (bus.Valid !== 1'b1 || bus.PC4Out !== 32'h204 || bus.InstructionOut !== mem_word(32'h200)) begin
            bad++; $display("FAIL same_refill: got %b/%h/%h want 1/%h/00000204", bus.Valid, bus.InstructionOut, bus.PC4Out, mem_word(32'h200));
        end
        if (sb.size() != 0) void'(sb.pop_front());
    endtask

    task automatic test_reset_mid();
        do_reset(3);
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0);
        Rst = 1'b0;
        #1;
        total++; if (bus.ImemReq !== 1'b0 || bus.Valid !== 1'b0 || bus.ImemAddr !== 32'h0) begin
            bad++; $display("FAIL mid_rst: got %b/%b/%h want 0/0/00000000", bus.ImemReq, bus.Valid, bus.ImemAddr);
        end
        bus.ImemAck  = 1'b1;
        bus.ImemData = 32'hBAD0_BAD0;
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        bus.ImemAck = 1'b0;
        total++; if (bus.ImemReq !== 1'b1 || bus.Valid !== 1'b0) begin
            bad++; $display("FAIL late_ack: got req %b valid %b want 1/0", bus.ImemReq, bus.Valid);
        end
        @(negedge Clk);
        total++; if (bus.Valid !== 1'b0) begin bad++; $display("FAIL late_ack_push: valid got %b want 0", bus.Valid); end
    endtask

    task automatic test_wrap();
        ent_t e;
        repeat (8) @(negedge Clk);
        total++; if (bus2.ImemReq !== 1'b0 || bus2.Valid !== 1'b1) begin
            bad++; $display("FAIL wrap_full: got req %b valid %b want 0/1", bus2.ImemReq, bus2.Valid);
        end
        e.ins = mem_word(32'hFFFF_FFF8); e.pc4 = 32'hFFFF_FFFC; sb2.push_back(e);
        e.ins = mem_word(32'hFFFF_FFFC); e.pc4 = 32'h0000_0000; sb2.push_back(e);
        e.ins = mem_word(32'h0000_0000); e.pc4 = 32'h0000_0004; sb2.push_back(e);
        e.ins = mem_word(32'h0000_0004); e.pc4 = 32'h0000_0008; sb2.push_back(e);
        for (int k = 0; k < 4; k++) begin
            bus2.Stall = 1'b0;
            e = sb2.pop_front();
            total++; if (bus2.Valid !== 1'b1 || bus2.InstructionOut !== e.ins || bus2.PC4Out !== e.pc4) begin
                bad++; $display("FAIL wrap_pop%0d: got %b/%h/%h want 1/%h/%h", k, bus2.Valid, bus2.InstructionOut, bus2.PC4Out, e.ins, e.pc4);
            end
            @(negedge Clk);
        end
        bus2.Stall = 1'b1;
    endtask

    initial begin
        bus2.Stall = 1'b1;
        test_reset();
        test_stream();
        test_stall();
        test_latency();
        test_redirect_pending();
        test_redirect_same_edge();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
